hankel_seq: RTL and testbench

HANKEL_SEQ -- requirements
Module: hankel_seq

---
 rtl/hankel_pkg.sv | 12 +
 rtl/hankel_skid_fifo.sv | 70 +++++++
 rtl/hankel_seq.sv | 150 +++++++++++++++
 tb/tb_hankel_seq.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hankel_pkg.sv
// Shared definitions for the Hankel-matrix read sequencer: FSM encoding and index width.
package hankel_pkg;

  localparam int IDX_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/hankel_skid_fifo.sv
// Two-entry output buffer: head entry drives the stream, second entry absorbs one stalled beat.
module hankel_skid_fifo #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] e0_q, e0_d;
  logic [DATA_W-1:0] e1_q, e1_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              pop_ok;

  assign pop_ok = pop && (cnt_q != 2'd0);

  // Upstream credit check guarantees no push lands on a full buffer without a pop.
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      case ({push, pop_ok})
        2'b10: begin
          if (cnt_q == 2'd0) e0_d = push_data;
          else               e1_d = push_data;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          e0_d  = e1_q;
          cnt_d = cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            e0_d = push_data;
          end else begin
            e0_d = e1_q;
            e1_d = push_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = e0_q;
  assign count     = cnt_q;

endmodule

// File: rtl/hankel_seq.sv
// Streams a ROW x COL Hankel matrix (element (r,c) = sample[r+c]) from a 1-cycle-latency memory.
// Optional HANKEL_SEQ_ABORT_EN adds an abort input that cancels a pass in progress.
import hankel_pkg::*;

module hankel_seq #(
  parameter int N     = 15,
  parameter int ROW   = (N + 1) / 2,
  parameter int COL   = ROW,
  parameter int WIDTH = 16,
  parameter int ADDR  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef HANKEL_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic             mem_rd,
  output logic [ADDR-1:0]  mem_addr,
  input  logic [WIDTH-1:0] mem_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [IDX_W-1:0] m_row,
  output logic [IDX_W-1:0] m_col,
  output logic             m_last
);

  localparam int PW = 1 + 2 * IDX_W + WIDTH;

  if ((ROW + COL - 2) >= (2 ** ADDR) || ROW > 255 || COL > 255) begin : g_param_err
    $error("hankel_seq: ROW/COL out of range for ADDR or index width");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] rd_r_q, rd_r_d;
  logic [IDX_W-1:0] rd_c_q, rd_c_d;
  logic             inf_q, inf_d;
  logic [IDX_W-1:0] inf_r_q, inf_r_d;
  logic [IDX_W-1:0] inf_c_q, inf_c_d;
  logic             inf_last_q, inf_last_d;
  logic             done_q, done_d;

  logic             fire;
  logic             rd_last;
  logic             kill;
  logic [1:0]       fifo_cnt;
  logic [1:0]       occ;
  logic [IDX_W:0]   addr_sum;
  logic [PW-1:0]    head;

`ifdef HANKEL_SEQ_ABORT_EN
  assign kill = abort && (state_q != IDLE);
`else
  assign kill = 1'b0;
`endif

  assign fire    = m_valid && m_ready;
  assign rd_last = (rd_r_q == IDX_W'(ROW - 1)) && (rd_c_q == IDX_W'(COL - 1));
  // Credit counts the slot freed by this cycle's transfer so a full-rate stream never stalls.
  assign occ     = fifo_cnt - {1'b0, fire} + {1'b0, inf_q};

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (mem_rd && rd_last) state_d = DRAIN;
      DRAIN:   if (fire && m_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (kill) state_d = IDLE;
  end

  // Outputs and read-side datapath
  always_comb begin
    busy       = (state_q != IDLE);
    mem_rd     = (state_q == RUN) && (occ < 2'd2) && !kill;
    addr_sum   = {1'b0, rd_r_q} + {1'b0, rd_c_q};
    mem_addr   = mem_rd ? ADDR'(addr_sum) : '0;
    done_d     = (state_q == DRAIN) && fire && m_last && !kill;

    rd_r_d     = rd_r_q;
    rd_c_d     = rd_c_q;
    if (state_q == IDLE) begin
      rd_r_d = '0;
      rd_c_d = '0;
    end else if (mem_rd) begin
      if (rd_c_q == IDX_W'(COL - 1)) begin
        rd_c_d = '0;
        rd_r_d = rd_r_q + IDX_W'(1);
      end else begin
        rd_c_d = rd_c_q + IDX_W'(1);
      end
    end

    inf_d      = mem_rd;
    inf_r_d    = mem_rd ? rd_r_q  : inf_r_q;
    inf_c_d    = mem_rd ? rd_c_q  : inf_c_q;
    inf_last_d = mem_rd ? rd_last : inf_last_q;
  end

  // State and control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_r_q     <= '0;
      rd_c_q     <= '0;
      inf_q      <= 1'b0;
      inf_r_q    <= '0;
      inf_c_q    <= '0;
      inf_last_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_r_q     <= rd_r_d;
      rd_c_q     <= rd_c_d;
      inf_q      <= inf_d;
      inf_r_q    <= inf_r_d;
      inf_c_q    <= inf_c_d;
      inf_last_q <= inf_last_d;
      done_q     <= done_d;
    end
  end

  assign done = done_q;

  // Returning read data is tagged with the indices captured when it was issued.
  hankel_skid_fifo #(
    .DATA_W (PW)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (kill),
    .push      (inf_q && !kill),
    .push_data ({inf_last_q, inf_r_q, inf_c_q, mem_data}),
    .pop       (m_ready),
    .out_valid (m_valid),
    .out_data  (head),
    .count     (fifo_cnt)
  );

  assign m_data = head[WIDTH-1:0];
  assign m_col  = head[WIDTH +: IDX_W];
  assign m_row  = head[WIDTH+IDX_W +: IDX_W];
  assign m_last = head[PW-1];

endmodule

// File: tb/tb_hankel_seq.sv
// Scoreboard bench for hankel_seq: directed passes push expected elements, a monitor pops on handshake.
module tb_hankel_seq;

  localparam int ROW   = 8;
  localparam int COL   = 8;
  localparam int WIDTH = 16;
  localparam int ADDR  = 8;
  localparam int NEL   = ROW * COL;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             busy, done;
  logic             mem_rd;
  logic [ADDR-1:0]  mem_addr;
  logic [WIDTH-1:0] mem_data;
  logic             m_valid, m_ready;
  logic [WIDTH-1:0] m_data;
  logic [7:0]       m_row, m_col;
  logic             m_last;
`ifdef HANKEL_SEQ_ABORT_EN
  logic             abort;
`endif

  hankel_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
`ifdef HANKEL_SEQ_ABORT_EN
    .abort    (abort),
`endif
    .busy     (busy),
    .done     (done),
    .mem_rd   (mem_rd),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_row    (m_row),
    .m_col    (m_col),
    .m_last   (m_last)
  );

  always #5 clk = ~clk;

  // Sample memory: word at address a holds a + 100, one cycle read latency.
  always @(posedge clk) begin
    if (mem_rd) mem_data <= WIDTH'(mem_addr) + WIDTH'(100);
  end

  typedef struct {
    logic [7:0]       r;
    logic [7:0]       c;
    logic [WIDTH-1:0] d;
    logic             last;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   xfers  = 0;
  int   dones  = 0;
  int   reads  = 0;
  int   ready_mode = 0;
  logic ready_fixed = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  always @(posedge clk) begin
    if (done) dones++;
    if (mem_rd) reads++;
  end

  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      m_ready = (ready_mode != 0) ? 1'($urandom_range(0, 1)) : ready_fixed;
    end
  end

  // Monitor: compare every transfer against the scoreboard and check stall stability.
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_d;
  logic [7:0]       prev_r, prev_c;
  logic             prev_l;

  always @(negedge clk) begin
    logic abort_now;
    exp_t e;
    abort_now = 1'b0;
`ifdef HANKEL_SEQ_ABORT_EN
    abort_now = abort;
`endif
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (!mem_rd) chk("addr_idle", 64'(mem_addr), 64'd0);
      if (prev_stall) begin
        chk("stall_data", 64'(m_data), 64'(prev_d));
        chk("stall_idx", 64'({m_last, m_row, m_col}), 64'({prev_l, prev_r, prev_c}));
      end
      if (m_valid && m_ready && !abort_now) begin
        if (q.size() == 0) begin
          chk("unexpected_elem", 64'({m_row, m_col}), 64'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("elem_data", 64'(m_data), 64'(e.d));
          chk("elem_rc", 64'({m_row, m_col}), 64'({e.r, e.c}));
          chk("elem_last", 64'(m_last), 64'(e.last));
        end
        xfers++;
      end
      prev_stall = m_valid && !m_ready;
      prev_d = m_data;
      prev_r = m_row;
      prev_c = m_col;
      prev_l = m_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pass();
    exp_t e;
    for (int r = 0; r < ROW; r++) begin
      for (int c = 0; c < COL; c++) begin
        e.r = 8'(r);
        e.c = 8'(c);
        e.d = WIDTH'(r + c + 100);
        e.last = (r == ROW - 1) && (c == COL - 1);
        q.push_back(e);
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit, output int n);
    n = 0;
    while (!done && n < limit) begin
      tick();
      n++;
    end
    chk(name, 64'(done), 64'd1);
  endtask

  // Full-rate pass with latency and throughput checks.
  task automatic full_pass(input string tag);
    int n, d0, x0;
    d0 = dones;
    x0 = xfers;
    push_pass();
    pulse_start();
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    n = 0;
    while (!m_valid && n < 10) begin
      tick();
      n++;
    end
    chk({tag, "_first_valid_lat"}, 64'(n), 64'd2);
    wait_done({tag, "_done"}, 500, n);
    chk({tag, "_cycles"}, 64'(n), 64'd64);
    tick();
    tick();
    chk({tag, "_xfers"}, 64'(xfers - x0), 64'(NEL));
    chk({tag, "_done_once"}, 64'(dones - d0), 64'd1);
    chk({tag, "_busy_end"}, 64'(busy), 64'd0);
    chk({tag, "_queue_empty"}, 64'(q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog timeout t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d0, x0, r0;
    rst = 1'b1;
    start = 1'b0;
`ifdef HANKEL_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(m_valid), 64'd0);
    chk("rst_mem_rd", 64'(mem_rd), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst = 1'b0;
    tick();

    // Basic full-rate pass.
    ready_mode = 0;
    ready_fixed = 1'b1;
    full_pass("p1");

    // Random backpressure.
    ready_mode = 1;
    d0 = dones;
    x0 = xfers;
    push_pass();
    pulse_start();
    wait_done("rand_done", 2000, n);
    ready_mode = 0;
    ready_fixed = 1'b1;
    tick();
    tick();
    chk("rand_xfers", 64'(xfers - x0), 64'(NEL));
    chk("rand_done_once", 64'(dones - d0), 64'd1);
    chk("rand_queue_empty", 64'(q.size()), 64'd0);

    // Stalled from the start: at most two reads may issue.
    ready_fixed = 1'b0;
    tick();
    d0 = dones;
    r0 = reads;
    push_pass();
    pulse_start();
    repeat (20) tick();
    chk("stall_reads", 64'(reads - r0), 64'd2);
    chk("stall_mem_rd", 64'(mem_rd), 64'd0);
    chk("stall_valid", 64'(m_valid), 64'd1);
    ready_fixed = 1'b1;
    wait_done("stall_done", 500, n);
    tick();
    tick();
    chk("stall_done_once", 64'(dones - d0), 64'd1);
    chk("stall_queue_empty", 64'(q.size()), 64'd0);

    // Reset in the middle of a pass.
    x0 = xfers;
    push_pass();
    pulse_start();
    n = 0;
    while ((xfers - x0) < 30 && n < 200) begin
      tick();
      n++;
    end
    chk("midrst_reach30", 64'((xfers - x0) >= 30), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_mem_rd", 64'(mem_rd), 64'd0);
    chk("midrst_addr", 64'(mem_addr), 64'd0);
    chk("midrst_valid", 64'(m_valid), 64'd0);
    chk("midrst_last", 64'(m_last), 64'd0);
    chk("midrst_data", 64'(m_data), 64'd0);
    chk("midrst_rc", 64'({m_row, m_col}), 64'd0);
    q.delete();
    d0 = dones;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("midrst_no_done", 64'(dones - d0), 64'd0);
    full_pass("p_after_rst");

    // Start mid-pass is ignored; start in the done cycle begins a back-to-back pass.
    d0 = dones;
    x0 = xfers;
    push_pass();
    push_pass();
    pulse_start();
    repeat (10) tick();
    pulse_start();
    wait_done("b2b_done1", 500, n);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("b2b_done2", 500, n);
    chk("b2b_cycles", 64'(n), 64'd66);
    tick();
    tick();
    chk("b2b_xfers", 64'(xfers - x0), 64'(2 * NEL));
    chk("b2b_dones", 64'(dones - d0), 64'd2);
    chk("b2b_queue_empty", 64'(q.size()), 64'd0);

`ifdef HANKEL_SEQ_ABORT_EN
    // Abort after ten elements, then a clean pass.
    x0 = xfers;
    push_pass();
    pulse_start();
    n = 0;
    while ((xfers - x0) < 10 && n < 200) begin
      tick();
      n++;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_valid", 64'(m_valid), 64'd0);
    q.delete();
    d0 = dones;
    repeat (3) tick();
    chk("abort_no_done", 64'(dones - d0), 64'd0);
    full_pass("p_after_abort");
`endif

    chk("final_queue_empty", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
